// File: rtl/ga_pkg.sv
// rtl/ga_pkg.sv - shared GA datapath types, LFSR constants and width helpers
package ga_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } sel_state_t;

    localparam logic [15:0] LFSR_TAPS_16      = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    localparam int GA_POPULATION_SIZE = 16;
    localparam int GA_FITNESS_WIDTH   = 10;
    localparam int GA_ADDR_WIDTH      = $clog2(GA_POPULATION_SIZE);
    localparam int GA_SUM_WIDTH       = GA_FITNESS_WIDTH + GA_ADDR_WIDTH;
    localparam int GA_LFSR_WIDTH      = 16;

endpackage

// File: rtl/ga_lfsr.sv
// rtl/ga_lfsr.sv - right-shift Galois LFSR, advances only while enable is high
module ga_lfsr
    import ga_pkg::*;
#(
    parameter int               WIDTH = GA_LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_16),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_SEED_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [WIDTH-1:0] random_out,
    output logic [WIDTH-1:0] random_next
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    // random_next is what the register will hold after one step, so callers
    // can use the fresh value in the same cycle they request the advance.
    always_comb begin
        random_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        lfsr_d      = enable ? random_next : lfsr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign random_out = lfsr_q;

endmodule

// File: rtl/roulette_selector.sv
// rtl/roulette_selector.sv - fitness-proportionate parent selector (SEL_EXCLUDE_PREV_EN: avoid repeating last index)
module roulette_selector
    import ga_pkg::*;
#(
    parameter int                    POPULATION_SIZE = GA_POPULATION_SIZE,
    parameter int                    FITNESS_WIDTH   = GA_FITNESS_WIDTH,
    parameter int                    ADDR_WIDTH      = $clog2(POPULATION_SIZE),
    parameter int                    SUM_WIDTH       = FITNESS_WIDTH + ADDR_WIDTH,
    parameter int                    LFSR_WIDTH      = GA_LFSR_WIDTH,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED       = LFSR_WIDTH'(LFSR_SEED_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_selection,
    input  logic [FITNESS_WIDTH-1:0] fitness_values [POPULATION_SIZE],
    input  logic [SUM_WIDTH-1:0]     total_fitness,
    output logic [ADDR_WIDTH-1:0]    selected_parent,
    output logic                     selection_done,
    output logic                     busy
);

    localparam int                    PROD_WIDTH = LFSR_WIDTH + SUM_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(POPULATION_SIZE - 1);

    sel_state_t            state_q, state_d;
    logic [SUM_WIDTH-1:0]  threshold_q, threshold_d;
    logic [SUM_WIDTH-1:0]  total_q, total_d;
    logic [SUM_WIDTH:0]    acc_q, acc_d, acc_sum;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] hit_idx;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  hit;
    logic                  lfsr_en;
    logic [LFSR_WIDTH-1:0] lfsr_value, lfsr_next;
    logic [PROD_WIDTH-1:0] product;
`ifdef SEL_EXCLUDE_PREV_EN
    logic [ADDR_WIDTH-1:0] prev_q, prev_d;
    logic                  prev_valid_q, prev_valid_d;
`endif

    ga_lfsr #(
        .WIDTH (LFSR_WIDTH),
        .TAPS  (LFSR_WIDTH'(LFSR_TAPS_16)),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (lfsr_en),
        .random_out  (lfsr_value),
        .random_next (lfsr_next)
    );

    always_comb begin
        state_d     = state_q;
        threshold_d = threshold_q;
        total_d     = total_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        sel_d       = sel_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        lfsr_en     = 1'b0;
        hit         = 1'b0;
        hit_idx     = idx_q;
`ifdef SEL_EXCLUDE_PREV_EN
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
`endif
        // Scaling a uniform LFSR word by the total keeps the threshold below
        // the total without a divider.
        product = PROD_WIDTH'(lfsr_next) * PROD_WIDTH'(total_fitness);
        acc_sum = acc_q + (SUM_WIDTH + 1)'(fitness_values[idx_q]);

        case (state_q)
            IDLE: begin
                if (start_selection) begin
                    lfsr_en     = 1'b1;
                    threshold_d = SUM_WIDTH'(product >> LFSR_WIDTH);
                    total_d     = total_fitness;
                    idx_d       = '0;
                    acc_d       = '0;
                    busy_d      = 1'b1;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (total_q == '0) begin
                    hit     = 1'b1;
                    hit_idx = ADDR_WIDTH'(lfsr_value);
                end else if (acc_sum > {1'b0, threshold_q} || idx_q == LAST_IDX) begin
                    hit = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                    acc_d = acc_sum;
                end
                if (hit) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

`ifdef SEL_EXCLUDE_PREV_EN
        if (hit) begin
            sel_d        = (prev_valid_q && hit_idx == prev_q) ? hit_idx + 1'b1 : hit_idx;
            prev_d       = sel_d;
            prev_valid_d = 1'b1;
        end
`else
        if (hit) begin
            sel_d = hit_idx;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            threshold_q  <= '0;
            total_q      <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            sel_q        <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SEL_EXCLUDE_PREV_EN
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            threshold_q  <= threshold_d;
            total_q      <= total_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            sel_q        <= sel_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
`ifdef SEL_EXCLUDE_PREV_EN
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
`endif
        end
    end

    assign selected_parent = sel_q;
    assign selection_done  = done_q;
    assign busy            = busy_q;

endmodule
